// File: rtl/reg_pipeline_hs_if.sv
// Handshake bundle for reg_pipeline_hs: upstream valid/ready/data,
// downstream valid/ready/data, a synchronous flush and the occupancy count.
// The pipeline itself connects through the slave modport.
interface reg_pipeline_hs_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  // Producer/consumer side: drives the inputs of the pipeline.
  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  // Pipeline side.
  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );
endinterface

// File: rtl/reg_pipeline_hs.sv
// Multi-stage register pipeline with valid/ready flow control.
// Each stage holds a WIDTH-bit word and a valid bit. Words move forward
// whenever the next stage is empty or is itself moving, so empty stages
// collapse as bubbles and a stall at the output backs up one stage at a
// time. The ready chain is combinational from out_ready, giving one word
// per cycle of throughput. Flush drops every held word at the next edge
// without touching the data registers.
module reg_pipeline_hs #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               clk,
  input logic               reset,
  reg_pipeline_hs_if.slave  bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [OCC_W-1:0] occ_q;

  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] stage_ready;
  logic [DEPTH-1:0] load;
  logic             in_xfer;
  logic             out_xfer;

  // Ready chain, walked from the output back to stage 0. A stage moves when
  // it holds a word and the stage after it is empty or moving; a stage is
  // ready when it is empty or moving. The running term is kept in a local
  // so the chain is one straight combinational pass.
  always_comb begin
    logic chain;
    move        = '0;
    stage_ready = '0;
    chain       = valid_q[DEPTH-1] & bus.out_ready & ~bus.flush;
    move[DEPTH-1]        = chain;
    stage_ready[DEPTH-1] = ~valid_q[DEPTH-1] | chain;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      chain          = valid_q[i] & (~valid_q[i+1] | chain);
      move[i]        = chain;
      stage_ready[i] = ~valid_q[i] | chain;
    end
  end

  // Load enables: stage 0 loads on an input transfer, every later stage
  // loads when it is ready and the stage behind it holds a word. Flush
  // suppresses all loads so data registers stay untouched that cycle.
  always_comb begin
    load    = '0;
    load[0] = in_xfer;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = stage_ready[i] & valid_q[i-1] & ~bus.flush;
    end
  end

  assign bus.in_ready  = stage_ready[0] & ~bus.flush;
  assign bus.out_valid = valid_q[DEPTH-1] & ~bus.flush;
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.occupancy = occ_q;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

  // Valid bits: a stage becomes full when it loads, stays full while it
  // neither loads nor moves, and empties when its word moves on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= load[i] | (valid_q[i] & ~move[i]);
      end
    end
  end

  // Data registers change only on load; an emptied stage keeps stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      if (load[0]) begin
        data_q[0] <= bus.in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  // Occupancy tracks words held: up on an input transfer, down on an
  // output transfer, cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else if (bus.flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end
endmodule

// File: tb/tb_reg_pipeline_hs.sv
// Self-checking bench for reg_pipeline_hs (WIDTH=8, DEPTH=3, RESET_VAL=A5).
// The reference model is a queue of in-flight words, each tagged with how
// far down the pipeline it has travelled; words advance one step per edge
// unless blocked by the word ahead of them.
module tb_reg_pipeline_hs;
  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RV    = 8'hA5;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               pos;
  } tok_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int   n_checks = 0;
  int   n_pass   = 0;

  tok_t model_q[$];
  int   new_pos[$];

  reg_pipeline_hs_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  reg_pipeline_hs #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_VAL(RV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] data,
                               input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = data;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Where each remaining word will sit after the next edge.
  function automatic void computePositions(input bit leave);
    int ahead;
    int p;
    ahead = DEPTH;
    new_pos.delete();
    for (int k = (leave ? 1 : 0); k < model_q.size(); k++) begin
      p = model_q[k].pos + 1;
      if (p > ahead - 1) p = ahead - 1;
      new_pos.push_back(p);
      ahead = p;
    end
  endfunction

  function automatic bit predOutValid();
    return !bus.flush && model_q.size() > 0 && model_q[0].pos == DEPTH - 1;
  endfunction

  function automatic bit predInReady();
    bit leave;
    if (bus.flush) return 1'b0;
    leave = predOutValid() && bus.out_ready;
    computePositions(leave);
    return new_pos.size() == 0 || new_pos[new_pos.size()-1] >= 1;
  endfunction

  task automatic checkCycle(input string tag);
    bit ov;
    ov = predOutValid();
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'(ov));
    checkOutput({tag, " in_ready"},  32'(bus.in_ready),  32'(predInReady()));
    checkOutput({tag, " occupancy"}, 32'(bus.occupancy), 32'(model_q.size()));
    if (ov) checkOutput({tag, " out_data"}, 32'(bus.out_data), 32'(model_q[0].data));
  endtask

  task automatic updateModel();
    bit   ov;
    bit   ir;
    bit   leave;
    tok_t t;
    if (bus.flush) begin
      model_q.delete();
    end else begin
      ov    = predOutValid();
      ir    = predInReady();
      leave = ov && bus.out_ready;
      computePositions(leave);
      if (leave) void'(model_q.pop_front());
      for (int k = 0; k < model_q.size(); k++) model_q[k].pos = new_pos[k];
      if (bus.in_valid && ir) begin
        t.data = bus.in_data;
        t.pos  = 0;
        model_q.push_back(t);
      end
    end
  endtask

  // One clock: check at the falling edge, then advance the model after the rising edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    checkCycle(tag);
    @(posedge clk);
    #1;
    updateModel();
  endtask

  initial begin
    // Reset asserted between edges with no clock edge yet.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset out_data",  32'(bus.out_data),  32'(RV));
    checkOutput("reset occupancy", 32'(bus.occupancy), 32'd0);
    checkOutput("reset in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Streaming at full rate.
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0); cycle("stream");
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0); cycle("stream");
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0); cycle("stream");
    checkOutput("stream first out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("stream first out_data",  32'(bus.out_data),  32'h11);
    applyStimulus(1'b1, 8'h44, 1'b1, 1'b0); cycle("stream");
    checkOutput("stream second out_data", 32'(bus.out_data),  32'h22);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); cycle("drain");
    end

    // Stall: five pushes against out_ready=0, only three fit.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0); cycle("stall");
    end
    checkOutput("stall occupancy", 32'(bus.occupancy), 32'd3);
    checkOutput("stall in_ready",  32'(bus.in_ready),  32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); cycle("release");
    end

    // Bubble collapse: word, two idle cycles, word, with out_ready=0.
    applyStimulus(1'b1, 8'h61, 1'b0, 1'b0); cycle("bubble");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0); cycle("bubble");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0); cycle("bubble");
    applyStimulus(1'b1, 8'h62, 1'b0, 1'b0); cycle("bubble");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0); cycle("bubble");
    checkOutput("bubble occupancy", 32'(bus.occupancy), 32'd2);
    checkOutput("bubble out_data",  32'(bus.out_data),  32'h61);

    // Flush with two words held; held words must never emerge.
    applyStimulus(1'b1, 8'h70, 1'b1, 1'b1);
    #1;
    checkOutput("flush out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush in_ready",  32'(bus.in_ready),  32'd0);
    cycle("flush");
    checkOutput("flush occupancy", 32'(bus.occupancy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); cycle("post-flush");
    end

    // Fill the pipeline, then reset between edges.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0); cycle("fill");
    end
    #2 reset = 1'b1;
    #1;
    model_q.delete();
    checkOutput("midreset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midreset out_data",  32'(bus.out_data),  32'(RV));
    checkOutput("midreset occupancy", 32'(bus.occupancy), 32'd0);
    checkOutput("midreset in_ready",  32'(bus.in_ready),  32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'h91, 1'b1, 1'b0); cycle("restart");
    applyStimulus(1'b1, 8'h92, 1'b1, 1'b0); cycle("restart");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); cycle("restart");
    checkOutput("restart out_data", 32'(bus.out_data), 32'h91);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0); cycle("restart");
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, 8'($urandom_range(0, 255)),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
      cycle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
